// File: rtl/sseg_scan_ctrl_if.sv
// Bundle between a display-value producer and the seven-segment scan controller.
// The producer drives the value/strobe/mode side; the controller drives the panel side.
interface sseg_scan_ctrl_if;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        lzb;
  logic        enable;
  logic [3:0]  digit_code;
  logic [3:0]  an;
  logic        dp_n;
  logic        pending;

  modport master (
    output value_in, dp_in, load, lzb, enable,
    input  digit_code, an, dp_n, pending
  );

  modport slave (
    input  value_in, dp_in, load, lzb, enable,
    output digit_code, an, dp_n, pending
  );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Four-digit common-anode display scanner sharing one hex_to_sseg decoder.
// New values are staged and only swapped in at frame boundaries so a frame is never torn.
module sseg_scan_ctrl #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  sseg_scan_ctrl_if.slave   bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      dispVal_q, dispVal_d;
  logic [3:0]       dispDp_q, dispDp_d;
  logic [15:0]      pendVal_q, pendVal_d;
  logic [3:0]       pendDp_q, pendDp_d;
  logic             pendV_q, pendV_d;
  logic [3:0]       digitCode_q, digitCode_d;
  logic [3:0]       an_q, an_d;
  logic             dpN_q, dpN_d;

  logic             slotAdv;
  logic             frameEnd;
  logic [3:0]       nibble;
  logic             upperZero;
  logic             blank;

  // Outputs are computed from the post-edge idx/disp so they move together with the slot advance.
  always_comb begin
    slotAdv   = (cnt_q == CNT_LAST);
    frameEnd  = slotAdv && (idx_q == 2'd3);
    cnt_d     = slotAdv ? '0 : cnt_q + CNT_W'(1);
    idx_d     = slotAdv ? idx_q + 2'd1 : idx_q;

    dispVal_d = dispVal_q;
    dispDp_d  = dispDp_q;
    pendVal_d = pendVal_q;
    pendDp_d  = pendDp_q;
    pendV_d   = pendV_q;

    if (bus.load && frameEnd) begin
      dispVal_d = bus.value_in;
      dispDp_d  = bus.dp_in;
      pendV_d   = 1'b0;
    end else if (bus.load) begin
      pendVal_d = bus.value_in;
      pendDp_d  = bus.dp_in;
      pendV_d   = 1'b1;
    end else if (frameEnd && pendV_q) begin
      dispVal_d = pendVal_q;
      dispDp_d  = pendDp_q;
      pendV_d   = 1'b0;
    end

    nibble    = 4'h0;
    upperZero = 1'b0;
    case (idx_d)
      2'd0: begin
        nibble    = dispVal_d[3:0];
        upperZero = 1'b0;
      end
      2'd1: begin
        nibble    = dispVal_d[7:4];
        upperZero = (dispVal_d[15:4] == 12'h000);
      end
      2'd2: begin
        nibble    = dispVal_d[11:8];
        upperZero = (dispVal_d[15:8] == 8'h00);
      end
      default: begin
        nibble    = dispVal_d[15:12];
        upperZero = (dispVal_d[15:12] == 4'h0);
      end
    endcase

    // Digit 0 never has upperZero set, so a zero value still shows a single 0.
    blank       = bus.lzb && upperZero;
    digitCode_d = blank ? 4'hF : nibble;
    dpN_d       = blank || !bus.enable || !dispDp_d[idx_d];
    an_d        = bus.enable ? ~(4'b0001 << idx_d) : 4'b1111;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      dispVal_q   <= 16'h0000;
      dispDp_q    <= 4'h0;
      pendVal_q   <= 16'h0000;
      pendDp_q    <= 4'h0;
      pendV_q     <= 1'b0;
      digitCode_q <= 4'h0;
      an_q        <= bus.enable ? 4'b1110 : 4'b1111;
      dpN_q       <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dispVal_q   <= dispVal_d;
      dispDp_q    <= dispDp_d;
      pendVal_q   <= pendVal_d;
      pendDp_q    <= pendDp_d;
      pendV_q     <= pendV_d;
      digitCode_q <= digitCode_d;
      an_q        <= an_d;
      dpN_q       <= dpN_d;
    end
  end

  assign bus.digit_code = digitCode_q;
  assign bus.an         = an_q;
  assign bus.dp_n       = dpN_q;
  assign bus.pending    = pendV_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl with REFRESH_DIV=4 (16-cycle frames).
// pos counts edges since reset: cnt = pos%4, idx = (pos/4)%4.
module tb_sseg_scan_ctrl;
  localparam int RDIV = 4;

  logic clk = 1'b0;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;
  int   pos = 0;

  logic [3:0] anTab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] codeTab [4];
  logic       dpTab [4];

  sseg_scan_ctrl_if bus ();

  sseg_scan_ctrl #(.REFRESH_DIV(RDIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    pos++;
  endtask

  task automatic tickTo(input int target);
    while (pos < target) tick();
  endtask

  task automatic checkVal(input string tag, input logic [3:0] got, input logic [3:0] exp);
    compared++;
    assert (got === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expAn, input logic [3:0] expCode,
                             input logic expDp, input logic expPend);
    checkVal({tag, ".an"},   bus.an,                 expAn);
    checkVal({tag, ".code"}, bus.digit_code,         expCode);
    checkVal({tag, ".dp_n"}, {3'b000, bus.dp_n},     {3'b000, expDp});
    checkVal({tag, ".pend"}, {3'b000, bus.pending},  {3'b000, expPend});
  endtask

  task automatic applyStimulus(input logic [15:0] value, input logic [3:0] dp);
    bus.value_in = value;
    bus.dp_in    = dp;
    bus.load     = 1'b1;
    tick();
    bus.load     = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    bus.value_in = 16'h0000;
    bus.dp_in    = 4'h0;
    bus.load     = 1'b0;
    bus.lzb      = 1'b0;
    bus.enable   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    pos   = 0;

    // Free-running scan of an all-zero value over two frames
    for (int k = 0; k < 32; k++) begin
      checkOutput($sformatf("scan%0d", k), anTab[(k / 4) % 4], 4'h0, 1'b1, 1'b0);
      tick();
    end

    // Load at cnt=1 idx=1, applied at the next boundary
    tickTo(37);
    applyStimulus(16'h1234, 4'b0100);
    checkVal("fal.pend", {3'b000, bus.pending}, 4'h1);
    tickTo(47);
    checkOutput("fal.before", 4'b0111, 4'h0, 1'b1, 1'b1);
    tick();
    checkOutput("fal.edge", 4'b1110, 4'h4, 1'b1, 1'b0);
    codeTab = '{4'h4, 4'h3, 4'h2, 4'h1};
    dpTab   = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      tickTo(49 + 4 * i);
      checkOutput($sformatf("fal.d%0d", i), anTab[i], codeTab[i], dpTab[i], 1'b0);
    end

    // Load coinciding with the boundary edge shows immediately
    tickTo(63);
    applyStimulus(16'h0005, 4'b0000);
    checkOutput("bnd.edge", 4'b1110, 4'h5, 1'b1, 1'b0);
    tick();
    checkVal("bnd.pend", {3'b000, bus.pending}, 4'h0);

    // Two loads in one frame: the second wins
    tickTo(66);
    applyStimulus(16'h0011, 4'b0000);
    checkVal("ovw.pend", {3'b000, bus.pending}, 4'h1);
    tickTo(70);
    applyStimulus(16'h0022, 4'b0000);
    checkOutput("ovw.old", 4'b1101, 4'h0, 1'b1, 1'b1);
    tickTo(80);
    checkOutput("ovw.new0", 4'b1110, 4'h2, 1'b1, 1'b0);
    tickTo(84);
    checkOutput("ovw.new1", 4'b1101, 4'h2, 1'b1, 1'b0);

    // Leading-zero blanking of 0070 with a dp on the blanked digit 3
    tickTo(89);
    bus.lzb = 1'b1;
    applyStimulus(16'h0070, 4'b1000);
    checkOutput("lzb.old2", 4'b1011, 4'hF, 1'b1, 1'b1);
    codeTab = '{4'h0, 4'h7, 4'hF, 4'hF};
    for (int i = 0; i < 4; i++) begin
      tickTo(97 + 4 * i);
      checkOutput($sformatf("lzb.d%0d", i), anTab[i], codeTab[i], 1'b1, 1'b0);
    end

    // All-zero value with blanking: only digit 0 shows
    tickTo(110);
    applyStimulus(16'h0000, 4'b0000);
    codeTab = '{4'h0, 4'hF, 4'hF, 4'hF};
    for (int i = 0; i < 4; i++) begin
      tickTo(113 + 4 * i);
      checkOutput($sformatf("zero.d%0d", i), anTab[i], codeTab[i], 1'b1, 1'b0);
    end

    // Blanking off: 0070 shows all digits; lzb change lands on the very next edge
    tickTo(126);
    bus.lzb = 1'b0;
    applyStimulus(16'h0070, 4'b1000);
    checkOutput("nolzb.next", 4'b0111, 4'h0, 1'b1, 1'b1);
    codeTab = '{4'h0, 4'h7, 4'h0, 4'h0};
    dpTab   = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      tickTo(129 + 4 * i);
      checkOutput($sformatf("nolzb.d%0d", i), anTab[i], codeTab[i], dpTab[i], 1'b0);
    end

    // Mid-slot lzb toggle
    tickTo(153);
    bus.lzb = 1'b1;
    tick();
    checkOutput("lzbtog.on", 4'b1011, 4'hF, 1'b1, 1'b0);
    bus.lzb = 1'b0;
    tick();
    checkOutput("lzbtog.off", 4'b1011, 4'h0, 1'b1, 1'b0);

    // Enable low for 10 edges starting mid-slot at idx 2
    tickTo(169);
    bus.enable = 1'b0;
    tick();
    checkOutput("en.off2", 4'b1111, 4'h0, 1'b1, 1'b0);
    tickTo(173);
    checkOutput("en.off3", 4'b1111, 4'h0, 1'b1, 1'b0);
    tickTo(177);
    checkOutput("en.off0", 4'b1111, 4'h0, 1'b1, 1'b0);
    tickTo(179);
    bus.enable = 1'b1;
    checkOutput("en.last", 4'b1111, 4'h0, 1'b1, 1'b0);
    tick();
    checkOutput("en.back", 4'b1101, 4'h7, 1'b1, 1'b0);

    // Reset with a pending value and a simultaneous load
    tickTo(185);
    applyStimulus(16'h0099, 4'b1111);
    checkVal("rst.pendpre", {3'b000, bus.pending}, 4'h1);
    reset        = 1'b1;
    bus.value_in = 16'h0088;
    bus.dp_in    = 4'b1111;
    bus.load     = 1'b1;
    tick();
    reset    = 1'b0;
    bus.load = 1'b0;
    pos      = 0;
    checkOutput("rst.now", 4'b1110, 4'h0, 1'b1, 1'b0);
    tickTo(16);
    checkOutput("rst.f1d0", 4'b1110, 4'h0, 1'b1, 1'b0);
    tickTo(21);
    checkOutput("rst.f1d1", 4'b1101, 4'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
